// File: rtl/inst_encoder.sv
// inst_encoder: builds RV32I instruction words from decoder-style
// micro-operation descriptors, buffers them in a small FIFO and streams
// them into instruction memory at an auto-incrementing word address.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   prog_start                restart address/count, clear err_illegal
//   enc_valid/enc_ready       descriptor handshake (ready = FIFO not full)
//   enc_op, enc_funct3, enc_shift, enc_rd, enc_rs1, enc_rs2, enc_imm
//                             descriptor fields
//   mem_wr_en/mem_wr_ready    memory write handshake (en = FIFO not empty)
//   mem_wr_addr, mem_wr_data  word address and instruction word
//   words_written             completed writes since prog_start (saturating)
//   err_illegal               sticky flag for dropped unencodable descriptors
module inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [4:0]        enc_op,
    input  logic [2:0]        enc_funct3,
    input  logic [1:0]        enc_shift,
    input  logic [4:0]        enc_rd,
    input  logic [4:0]        enc_rs1,
    input  logic [4:0]        enc_rs2,
    input  logic [31:0]       enc_imm,
    output logic              mem_wr_en,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0]      enc_word_c;
    logic             enc_legal_c;
    logic [2:0]       f3_c;
    logic [6:0]       f7_c;

    logic [31:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    // Descriptor to instruction word; unused register fields stay zero.
    always_comb begin
        enc_word_c  = '0;
        enc_legal_c = 1'b1;
        f3_c        = 3'b000;
        f7_c        = 7'b0000000;
        case (enc_op)
            5'd0:  enc_word_c = {enc_imm[11:0], enc_rs1, 3'b010, enc_rd, OPC_LOAD};
            5'd2:  enc_word_c = {enc_imm[11:5], enc_rs2, enc_rs1, 3'b010,
                                 enc_imm[4:0], OPC_STORE};
            5'd4, 5'd5, 5'd6, 5'd7, 5'd24: begin
                case (enc_op)
                    5'd5:    f3_c = 3'b111;
                    5'd6:    f3_c = 3'b100;
                    5'd7:    f3_c = 3'b110;
                    default: f3_c = 3'b000;
                endcase
                f7_c       = (enc_op == 5'd24) ? 7'b0100000 : 7'b0000000;
                enc_word_c = {f7_c, enc_rs2, enc_rs1, f3_c, enc_rd, OPC_R};
            end
            5'd8, 5'd9, 5'd10, 5'd11: begin
                case (enc_op)
                    5'd9:    f3_c = 3'b111;
                    5'd10:   f3_c = 3'b100;
                    5'd11:   f3_c = 3'b110;
                    default: f3_c = 3'b000;
                endcase
                enc_word_c = {enc_imm[11:0], enc_rs1, f3_c, enc_rd, OPC_I};
            end
            5'd12: enc_word_c = {enc_imm[31:12], enc_rd, OPC_LUI};
            5'd13: enc_word_c = {enc_imm[31:12], enc_rd, OPC_AUIPC};
            5'd14: enc_word_c = {enc_imm[20], enc_imm[10:1], enc_imm[11],
                                 enc_imm[19:12], enc_rd, OPC_JAL};
            5'd16: enc_word_c = {enc_imm[11:0], enc_rs1, 3'b000, enc_rd, OPC_JALR};
            5'd18: enc_word_c = 32'h0010_0073;
            5'd19, 5'd21: begin
                // op 19 covers BEQ/BNE, op 21 covers BLT/BGE/BLTU/BGEU
                enc_legal_c = (enc_op == 5'd19) ? (enc_funct3[2:1] == 2'b00)
                                                : enc_funct3[2];
                enc_word_c  = {enc_imm[12], enc_imm[10:5], enc_rs2, enc_rs1,
                               enc_funct3, enc_imm[4:1], enc_imm[11], OPC_BRANCH};
            end
            5'd27: begin
                enc_legal_c = (enc_shift != 2'b01);
                f3_c        = enc_shift[1] ? 3'b101 : 3'b001;
                f7_c        = (enc_shift == 2'b11) ? 7'b0100000 : 7'b0000000;
                enc_word_c  = {f7_c, enc_imm[4:0], enc_rs1, f3_c, enc_rd, OPC_I};
            end
            default: enc_legal_c = 1'b0;
        endcase
    end

    // Illegal descriptors are still handshaken but never stored.
    assign push = enc_valid & ~full_q & enc_legal_c;
    assign pop  = ~empty_q & mem_wr_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_n = count - CNT_W'(1);
        end
    end

    // FIFO storage, pointers and registered full/empty flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= enc_word_c;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_n;
            full_q  <= (count_n == CNT_W'(DEPTH));
            empty_q <= (count_n == '0);
        end
    end

    // Write address, completed-write counter and sticky error; prog_start wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr_addr   <= ADDR_W'(BASE_ADDR);
            words_written <= '0;
            err_illegal   <= 1'b0;
        end else if (prog_start) begin
            mem_wr_addr   <= ADDR_W'(BASE_ADDR);
            words_written <= '0;
            err_illegal   <= 1'b0;
        end else begin
            if (pop) begin
                mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
                if (words_written != '1) begin
                    words_written <= words_written + (ADDR_W + 1)'(1);
                end
            end
            if (enc_valid && !full_q && !enc_legal_c) begin
                err_illegal <= 1'b1;
            end
        end
    end

    assign enc_ready   = ~full_q;
    assign mem_wr_en   = ~empty_q;
    assign mem_wr_data = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_inst_encoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned BASE_B = 1022;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_start;
    logic        enc_valid;
    logic [4:0]  enc_op;
    logic [2:0]  enc_funct3;
    logic [1:0]  enc_shift;
    logic [4:0]  enc_rd, enc_rs1, enc_rs2;
    logic [31:0] enc_imm;
    logic        mem_wr_ready;

    logic              enc_ready, mem_wr_en, err_illegal;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [ADDR_W:0]   words_written;

    logic              b_enc_ready, b_mem_wr_en, b_err_illegal;
    logic [ADDR_W-1:0] b_mem_wr_addr;
    logic [31:0]       b_mem_wr_data;
    logic [ADDR_W:0]   b_words_written;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .prog_start(prog_start),
        .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_op(enc_op), .enc_funct3(enc_funct3), .enc_shift(enc_shift),
        .enc_rd(enc_rd), .enc_rs1(enc_rs1), .enc_rs2(enc_rs2), .enc_imm(enc_imm),
        .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .words_written(words_written), .err_illegal(err_illegal)
    );

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .prog_start(prog_start),
        .enc_valid(enc_valid), .enc_ready(b_enc_ready),
        .enc_op(enc_op), .enc_funct3(enc_funct3), .enc_shift(enc_shift),
        .enc_rd(enc_rd), .enc_rs1(enc_rs1), .enc_rs2(enc_rs2), .enc_imm(enc_imm),
        .mem_wr_en(b_mem_wr_en), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(b_mem_wr_addr), .mem_wr_data(b_mem_wr_data),
        .words_written(b_words_written), .err_illegal(b_err_illegal)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: queued words, address offset from base, count, error.
    logic [31:0] m_q[$];
    int unsigned m_off;
    int unsigned m_ww;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {legal, word}, built field by field with shifts and masks.
    function automatic logic [32:0] ref_encode(input logic [4:0] op, input logic [2:0] f3i,
                                               input logic [1:0] sh, input logic [4:0] rdi,
                                               input logic [4:0] rs1i, input logic [4:0] rs2i,
                                               input logic [31:0] imm);
        logic [31:0] r, a, b, f3, f7, w;
        logic        ok;
        r = 32'(rdi); a = 32'(rs1i); b = 32'(rs2i); f3 = 32'(f3i);
        f7 = 32'd0; w = 32'd0; ok = 1'b1;
        case (op)
            5'd0: w = ((imm & 32'hFFF) << 20) | (a << 15) | (32'd2 << 12) | (r << 7) | 32'h03;
            5'd2: w = (((imm >> 5) & 32'd127) << 25) | (b << 20) | (a << 15) | (32'd2 << 12)
                      | ((imm & 32'd31) << 7) | 32'h23;
            5'd4, 5'd5, 5'd6, 5'd7, 5'd24: begin
                f3 = (op == 5'd5) ? 32'd7 : (op == 5'd6) ? 32'd4 : (op == 5'd7) ? 32'd6 : 32'd0;
                f7 = (op == 5'd24) ? 32'd32 : 32'd0;
                w  = (f7 << 25) | (b << 20) | (a << 15) | (f3 << 12) | (r << 7) | 32'h33;
            end
            5'd8, 5'd9, 5'd10, 5'd11: begin
                f3 = (op == 5'd9) ? 32'd7 : (op == 5'd10) ? 32'd4 : (op == 5'd11) ? 32'd6 : 32'd0;
                w  = ((imm & 32'hFFF) << 20) | (a << 15) | (f3 << 12) | (r << 7) | 32'h13;
            end
            5'd12: w = (imm & 32'hFFFF_F000) | (r << 7) | 32'h37;
            5'd13: w = (imm & 32'hFFFF_F000) | (r << 7) | 32'h17;
            5'd14: w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                       | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12)
                       | (r << 7) | 32'h6F;
            5'd16: w = ((imm & 32'hFFF) << 20) | (a << 15) | (r << 7) | 32'h67;
            5'd18: w = 32'h0010_0073;
            5'd19, 5'd21: begin
                ok = (op == 5'd19) ? (f3 <= 32'd1) : (f3 >= 32'd4);
                w  = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (b << 20)
                     | (a << 15) | (f3 << 12) | (((imm >> 1) & 32'd15) << 8)
                     | (((imm >> 11) & 32'd1) << 7) | 32'h63;
            end
            5'd27: begin
                ok = (sh != 2'b01);
                f3 = (sh == 2'b00) ? 32'd1 : 32'd5;
                f7 = (sh == 2'b11) ? 32'd32 : 32'd0;
                w  = (f7 << 25) | ((imm & 32'd31) << 20) | (a << 15) | (f3 << 12) | (r << 7) | 32'h13;
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    task automatic check_all();
        chk("enc_ready", 32'(enc_ready), 32'(m_q.size() < int'(DEPTH)));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(m_q.size() != 0));
        chk("mem_wr_addr", 32'(mem_wr_addr), m_off % 1024);
        chk("b_mem_wr_addr", 32'(b_mem_wr_addr), (m_off + BASE_B) % 1024);
        chk("words_written", 32'(words_written), m_ww);
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        if (m_q.size() != 0) begin
            chk("mem_wr_data", mem_wr_data, m_q[0]);
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are compared.
    task automatic step();
        logic [32:0] e;
        int          sz;
        @(posedge clk);
        if (!rst) begin
            m_q.delete(); m_off = 0; m_ww = 0; m_err = 1'b0;
        end else begin
            e  = ref_encode(enc_op, enc_funct3, enc_shift, enc_rd, enc_rs1, enc_rs2, enc_imm);
            sz = m_q.size();
            if (sz != 0 && mem_wr_ready) begin
                void'(m_q.pop_front());
                m_off = (m_off + 1) % 1024;
                if (m_ww != 2047) m_ww++;
            end
            if (enc_valid && sz < int'(DEPTH)) begin
                if (e[32]) m_q.push_back(e[31:0]);
                else       m_err = 1'b1;
            end
            if (prog_start) begin
                m_off = 0; m_ww = 0; m_err = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic [1:0] sh, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        enc_valid = v; enc_op = op; enc_funct3 = f3; enc_shift = sh;
        enc_rd = rd; enc_rs1 = rs1; enc_rs2 = rs2; enc_imm = imm;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [1:0]  sh;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{5'd4,  3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
        tbl[1] = '{5'd24, 3'd0, 2'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3};
        tbl[2] = '{5'd8,  3'd0, 2'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF00293};
        tbl[3] = '{5'd27, 3'd0, 2'd3, 5'd5, 5'd6, 5'd0, 32'd3,          32'h40335293};
        tbl[4] = '{5'd2,  3'd0, 2'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
        tbl[5] = '{5'd19, 3'd0, 2'd0, 5'd0, 5'd1, 5'd2, 32'd16,         32'h00208863};
        tbl[6] = '{5'd14, 3'd0, 2'd0, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF};
        tbl[7] = '{5'd18, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0,          32'h00100073};
        tbl[8] = '{5'd12, 3'd0, 2'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000,  32'h123450B7};

        m_off = 0; m_ww = 0; m_err = 1'b0;
        rst = 1'b0; prog_start = 1'b0; mem_wr_ready = 1'b0;
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_wr_data", mem_wr_data, 32'd0);
        chk("rst b_addr", 32'(b_mem_wr_addr), 32'd1022);
        check_all();
        rst = 1'b1;
        step();

        // Directed table, one descriptor per cycle with memory always ready
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].f3, tbl[i].sh, tbl[i].rd, tbl[i].rs1,
                  tbl[i].rs2, tbl[i].imm);
            step();
            chk($sformatf("tbl%0d word", i), mem_wr_data, tbl[i].exp);
            chk($sformatf("tbl%0d addr", i), 32'(mem_wr_addr), 32'(i));
            chk($sformatf("tbl%0d ww", i), 32'(words_written), 32'(i));
        end
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        chk("tbl ww final", 32'(words_written), 32'd9);

        // Backpressure: five descriptors against a stalled memory
        prog_start = 1'b1; step(); prog_start = 1'b0;
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd8, 3'd0, 2'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i * 4));
            step();
        end
        chk("full enc_ready", 32'(enc_ready), 32'd0);
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) step();
        chk("held word", mem_wr_data, 32'h00000093);
        mem_wr_ready = 1'b1;
        repeat (5) step();
        chk("drain ww", 32'(words_written), 32'd4);

        // Illegal descriptors are dropped and flagged until prog_start
        drive(1'b1, 5'd21, 3'b010, 2'd0, 5'd0, 5'd1, 5'd2, 32'd4); step();
        drive(1'b1, 5'd3, 3'd0, 2'd0, 5'd1, 5'd1, 5'd1, 32'd0);    step();
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);    step();
        chk("illegal err", 32'(err_illegal), 32'd1);
        chk("illegal en", 32'(mem_wr_en), 32'd0);
        prog_start = 1'b1; step(); prog_start = 1'b0;
        chk("start err", 32'(err_illegal), 32'd0);
        chk("start addr", 32'(mem_wr_addr), 32'd0);

        // Address wrap on the BASE_ADDR=1022 instance
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 3'd0, 2'd0, 5'(i), 5'd1, 5'd2, 32'd0);
            step();
            chk($sformatf("wrap addr%0d", i), 32'(b_mem_wr_addr), (1022 + i) % 1024);
        end
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        chk("wrap b_ww", 32'(b_words_written), 32'd3);

        // prog_start coinciding with a pop
        mem_wr_ready = 1'b0;
        drive(1'b1, 5'd7, 3'd0, 2'd0, 5'd9, 5'd8, 5'd7, 32'd0); step();
        drive(1'b1, 5'd5, 3'd0, 2'd0, 5'd9, 5'd8, 5'd7, 32'd0); step();
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        mem_wr_ready = 1'b1; prog_start = 1'b1; step(); prog_start = 1'b0;
        chk("start+pop addr", 32'(mem_wr_addr), 32'd0);
        chk("start+pop ww", 32'(words_written), 32'd0);
        step();

        // Reset with two words buffered
        mem_wr_ready = 1'b0;
        drive(1'b1, 5'd6, 3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0); step();
        drive(1'b1, 5'd13, 3'd0, 2'd0, 5'd4, 5'd0, 5'd0, 32'hABCDE000); step();
        drive(1'b0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        rst = 1'b0;
        #1;
        m_q.delete(); m_off = 0; m_ww = 0; m_err = 1'b0;
        chk("midrst en", 32'(mem_wr_en), 32'd0);
        chk("midrst data", mem_wr_data, 32'd0);
        chk("midrst ready", 32'(enc_ready), 32'd1);
        chk("midrst b_addr", 32'(b_mem_wr_addr), 32'd1022);
        step();
        rst = 1'b1;
        step();

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] op;
            int ops[19] = '{0, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 16, 18, 19, 21, 24, 27};
            if ($urandom_range(0, 9) == 0) op = 5'($urandom);
            else                           op = 5'(ops[$urandom_range(0, 18)]);
            drive(1'($urandom_range(0, 3) != 0), op, 3'($urandom), 2'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom), 32'($urandom));
            mem_wr_ready = 1'($urandom_range(0, 2) != 0);
            prog_start   = ($urandom_range(0, 40) == 0);
            step();
        end
        prog_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Program-loader block that performs the inverse of the instruction decoder. It accepts micro-operation descriptors using the decoder's decode-address numbering, operand indices and immediate. From each descriptor it builds the 32-bit RV32I instruction word. Words are buffered in a small FIFO and streamed into instruction memory through a ready-qualified write port with an auto-incrementing word address. It is used by benches and boot logic to fill instruction memory ahead of the fetch/ID stages.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, word address loaded by prog_start
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- prog_start  in  1  pulse: address←BASE_ADDR, word count←0, err_illegal←0
- enc_valid  in  1  descriptor present
- enc_ready  out  1  descriptor accepted when enc_valid&enc_ready
- enc_op  in  5  decode address: 0 LW, 2 SW, 4 ADD, 5 AND, 6 XOR, 7 OR, 8 ADDI, 9 ANDI, 10 XORI, 11 ORI, 12 LUI, 13 AUIPC, 14 JAL, 16 JALR, 18 EBREAK, 19 BEQ/BNE, 21 BLT/BGE/BLTU/BGEU, 24 SUB, 27 shift-immediate
- enc_funct3  in  3  branch selector for ops 19/21
- enc_shift  in  2  for op 27: 00 SLLI, 10 SRLI, 11 SRAI
- enc_rd, enc_rs1, enc_rs2  in  5 each  architectural register order (never swapped)
- enc_imm  in  32  immediate in decoded (sign-extended, byte-offset) form
- mem_wr_en  out  1  write request (= FIFO not empty)
- mem_wr_ready  in  1  memory accepts write this cycle
- mem_wr_addr  out  ADDR_W  word address
- mem_wr_data  out  32  instruction word
- words_written  out  ADDR_W+1  writes completed since prog_start
- err_illegal  out  1  sticky: an unencodable descriptor was dropped

## Operation
- Encoding is combinational on the accepted descriptor. The encoded word is pushed into the FIFO; the FIFO head drives mem_wr_data.
- Opcodes: R 0110011, I-arith 0010011, LW 0000011 (f3 010), SW 0100011 (f3 010), branch 1100011, JAL 1101111, JALR 1100111 (f3 000), LUI 0110111, AUIPC 0010111.
- EBREAK: fixed word 0x00100073.
- R-type: f3/f7 are ADD 000/0, SUB 000/0100000, XOR 100/0, OR 110/0, AND 111/0.
- I-type: inst[31:20]=imm[11:0].
- Shifts: inst[24:20]=imm[4:0]. f7=0100000 only for SRAI. f3 is 001 for SLLI and 101 for SRLI/SRAI.
- S-type: imm[11:5]→[31:25], imm[4:0]→[11:7].
- B-type: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
- J-type: imm[20|10:1|11|19:12]→[31|30:21|20|19:12].
- U-type: imm[31:12]→[31:12].
- Unused register fields are 0. imm[0] is ignored for B and J types.
- Illegal descriptors are still accepted (enc_ready honoured) but not pushed, and they set err_illegal. Illegal cases:
  - any other enc_op;
  - op 19 with f3 not in {000, 001};
  - op 21 with f3 not in {100..111};
  - op 27 with enc_shift=01.
- Write: when mem_wr_en&mem_wr_ready, the head is popped, mem_wr_addr increments (wraps modulo 2^ADDR_W), and words_written increments (saturates at all-ones).
- prog_start does not flush the FIFO. Entries already buffered are written starting at BASE_ADDR.

## Timing
- Reset (rst low, immediate): FIFO empty, mem_wr_en=0, mem_wr_data=0, mem_wr_addr=BASE_ADDR, words_written=0, err_illegal=0, enc_ready=1.
- Release of reset is synchronous to clk.
- Latency: a descriptor accepted at edge N appears at mem_wr_en/mem_wr_data after edge N, i.e. in cycle N+1. Throughput is 1 word/cycle when mem_wr_ready=1.
- enc_ready = !full. It is registered-state based and has no combinational path from mem_wr_ready.
- Push and pop in the same cycle: both occur and the count is unchanged. When full, no push is possible that cycle even if a pop occurs.
- The write side holds mem_wr_data/mem_wr_addr stable while mem_wr_en&!mem_wr_ready.
- prog_start together with a pop: the prog_start values win (address=BASE_ADDR, count=0). The popped word is still written, at the pre-start address.
- Pointers wrap modulo DEPTH. Reset mid-stream discards all buffered words.

## Test plan
- Accept ADD rd=3, rs1=1, rs2=2 then SUB with the same operands, mem_wr_ready=1 → writes 0x002081B3 @0 and 0x402081B3 @1, words_written=2.
- Accept ADDI rd=5, rs1=0, imm=-1 and SRAI rd=5, rs1=6, imm=3, shift=11 → 0xFFF00293 and 0x40335293.
- Accept SW rs1=1, rs2=2, imm=8; BEQ rs1=1, rs2=2, imm=16, f3=000; JAL rd=1, imm=8 → 0x0020A423, 0x00208863, 0x008000EF.
- Hold mem_wr_ready=0 and push 5 descriptors → enc_ready drops after 4 (DEPTH). mem_wr_data is held stable. Releasing ready drains in order at consecutive addresses.
- Op 21 with f3=010, then op 3 → nothing written, err_illegal=1. prog_start clears it and sets mem_wr_addr=BASE_ADDR.
- Set BASE_ADDR=1022 with ADDR_W=10 and write 3 words → addresses 1022, 1023, 0. Assert rst low with 2 words buffered → immediate empty FIFO and all reset values.
